// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU between two valid/ready requesters using
//   round-robin arbitration. The ALU result is captured in a single-entry
//   output register with valid/ready backpressure. Accept and drain can
//   happen in the same cycle, so one op per cycle is sustained while the
//   consumer is ready.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   reqN_valid/ready            requester N handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_op     requester N operands and ALUOp
//   res_valid/ready             result handshake
//   res_data, res_id, res_zero  registered result, source index, zero flag
//   op_count                    accepted-operation counter (wraps)
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             res_zero,
  output logic [CNT_W-1:0] op_count
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
  } req_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  req_t [1:0]       req;
  logic [1:0]       vld;
  logic [1:0]       rdy;
  logic             gnt_vld;
  logic             gnt_idx;
  logic             can_accept;
  logic             accept;
  req_t             sel;
  logic [WIDTH-1:0] alu_res;

  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q,  res_data_d;
  logic             res_id_q,    res_id_d;
  logic             res_zero_q,  res_zero_d;
  logic             last_q,      last_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;

  assign req[0] = '{a: req0_a, b: req0_b, op: req0_op};
  assign req[1] = '{a: req1_a, b: req1_b, op: req1_op};
  assign vld    = {req1_valid, req0_valid};

  // Round-robin: on contention the requester that did not win last time
  // gets the ALU; a lone requester always wins.
  assign gnt_vld = |vld;
  assign gnt_idx = (&vld) ? ~last_q : vld[1];

  assign can_accept = !res_valid_q || res_ready;

  // rst_n gates ready so no handshake can complete while reset is held.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rdy
      assign rdy[gi] = rst_n && can_accept && gnt_vld && (gnt_idx == gi[0]);
    end
  endgenerate

  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];
  assign accept     = |(vld & rdy);
  assign sel        = req[gnt_idx];

  always_comb begin
    alu_res = '0;
    unique case (sel.op)
      OP_AND:  alu_res = sel.a & sel.b;
      OP_OR:   alu_res = sel.a | sel.b;
      OP_ADD:  alu_res = sel.a + sel.b;
      OP_SUB:  alu_res = sel.a - sel.b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (sel.a < sel.b)};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    res_zero_d  = res_zero_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    if (accept) begin
      // Covers both a fresh load and drain+load in the same cycle.
      res_valid_d = 1'b1;
      res_data_d  = alu_res;
      res_id_d    = gnt_idx;
      res_zero_d  = (alu_res == '0);
      last_d      = gnt_idx;
      cnt_d       = cnt_q + 1'b1;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
      res_zero_q  <= 1'b1;
      last_q      <= 1'b1;
      cnt_q       <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      res_zero_q  <= res_zero_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign res_zero  = res_zero_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a result scoreboard. Counter width is
// reduced to 4 bits so wrap-around is reachable quickly.
module tb_alu_arbiter;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]       req0_op, req1_op;
  logic             res_valid, res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_id, res_zero;
  logic [CNT_W-1:0] op_count;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .res_zero(res_zero),
    .op_count(op_count)
  );

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             id;
    logic             z;
  } exp_t;

  exp_t q[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state
  logic             m_vld;
  logic             m_last;
  logic [WIDTH-1:0] m_data;
  logic             m_id;
  logic             m_zero;
  int               m_cnt;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_alu(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return (a < b) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_vld = 0; m_last = 1; m_data = 0; m_id = 0; m_zero = 1; m_cnt = 0;
    q.delete();
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".res_valid"}, res_valid, m_vld);
    chk({tag, ".res_data"},  res_data,  m_data);
    chk({tag, ".res_id"},    res_id,    m_id);
    chk({tag, ".res_zero"},  res_zero,  m_zero);
    chk({tag, ".op_count"},  op_count,  m_cnt % (1 << CNT_W));
  endtask

  // One clock: called with clk low and inputs already driven.
  task automatic step(input string tag);
    logic ca, e0, e1, drained;
    exp_t e;
    #1;
    ca = !m_vld || res_ready;
    e0 = ca && req0_valid && (!req1_valid || m_last == 1'b1);
    e1 = ca && req1_valid && (!req0_valid || m_last == 1'b0);
    chk({tag, ".req0_ready"}, req0_ready, e0);
    chk({tag, ".req1_ready"}, req1_ready, e1);
    if (e0) begin
      e.d = ref_alu(req0_a, req0_b, req0_op); e.id = 0; e.z = (e.d == 0);
      q.push_back(e);
    end
    if (e1) begin
      e.d = ref_alu(req1_a, req1_b, req1_op); e.id = 1; e.z = (e.d == 0);
      q.push_back(e);
    end
    drained = m_vld && res_ready;
    @(posedge clk);
    #1;
    if (e0 || e1) begin
      if (q.size() == 0) begin
        chk({tag, ".scoreboard_empty"}, 1, 0);
      end else begin
        e = q.pop_front();
        m_vld = 1; m_data = e.d; m_id = e.id; m_zero = e.z;
        m_last = e.id; m_cnt++;
      end
    end else if (drained) begin
      m_vld = 0;
    end
    chk_outputs(tag);
    @(negedge clk);
  endtask

  task automatic set0(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] op);
    req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
  endtask

  task automatic set1(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] op);
    req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
  endtask

  initial begin
    rst_n = 0; res_ready = 1;
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    model_reset();
    #12;
    chk_outputs("reset");
    set0(1, 5, 3, 3'b010);
    #1;
    chk("reset.req0_ready", req0_ready, 0);
    set0(0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1;

    // Single op on requester 0
    set0(1, 5, 3, 3'b010);
    step("single");
    chk("single.data8", res_data, 32'd8);
    chk("single.cnt1", op_count, 1);
    set0(0, 0, 0, 0);
    step("single_drain");

    // Op coverage on requester 1
    set1(1, 32'hF0F0, 32'h0FF0, 3'b000); step("and");
    chk("and.val", res_data, 32'h00F0);
    set1(1, 32'hF0F0, 32'h0FF0, 3'b001); step("or");
    chk("or.val", res_data, 32'hFFF0);
    set1(1, 3, 5, 3'b110);               step("sub");
    chk("sub.val", res_data, 32'hFFFF_FFFE);
    set1(1, 3, 5, 3'b111);               step("slt_t");
    chk("slt_t.val", res_data, 1);
    set1(1, 32'hFFFF_FFFF, 1, 3'b111);   step("slt_f");
    chk("slt_f.val", res_data, 0);
    set1(1, 7, 9, 3'b011);               step("op011");
    chk("op011.zero", res_zero, 1);
    set1(0, 0, 0, 0);
    step("ops_drain");

    // Contention: alternating grants, one result per cycle
    set0(1, 10, 1, 3'b010);
    set1(1, 10, 1, 3'b110);
    for (int i = 0; i < 4; i++) begin
      step("contend");
      chk("contend.id", res_id, (i % 2 == 0) ? 0 : 1);
    end
    chk("contend.cnt", op_count, (1 + 6 + 4) % 16);

    // Backpressure with both requesters waiting
    res_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step("bp");
      chk("bp.data_stable", res_data, 9);
    end
    res_ready = 1;
    step("bp_release");
    chk("bp_release.valid", res_valid, 1);

    // Async reset mid-stream with a result pending
    res_ready = 0;
    step("pre_rst");
    #2;
    rst_n = 0;
    #1;
    model_reset();
    chk_outputs("async_rst");
    chk("async_rst.req0_ready", req0_ready, 0);
    chk("async_rst.req1_ready", req1_ready, 0);
    @(negedge clk);
    rst_n = 1;
    res_ready = 1;
    step("post_rst");
    chk("post_rst.id", res_id, 0);

    // Counter wrap: 17 accepted ops from reset -> 1
    set1(0, 0, 0, 0);
    for (int i = 1; i < 17; i++) begin
      set0(1, i, 2 * i, 3'b010);
      step("wrap");
    end
    chk("wrap.cnt", op_count, 1);

    set0(0, 0, 0, 0);
    step("final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    n_fail++;
    $display("FAIL timeout observed=running expected=finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one instance of the team's 32-bit ALU between two requesters (e.g. an execute stage and an address-generation unit).
- Uses valid/ready handshakes on both requester sides and round-robin arbitration.
- Registers the ALU result into a single-entry output stage with backpressure.
- Sustains one operation per cycle when the consumer is always ready.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU datapath.
- CNT_W, 16, width of the accepted-operation counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle when valid&ready
- req0_a  input  WIDTH  requester 0 operand A
- req0_b  input  WIDTH  requester 0 operand B
- req0_op  input  3  requester 0 ALUOp
- req1_valid  input  1  requester 1 has an operation
- req1_ready  output  1  requester 1 accept
- req1_a  input  WIDTH  requester 1 operand A
- req1_b  input  WIDTH  requester 1 operand B
- req1_op  input  3  requester 1 ALUOp
- res_valid  output  1  result register holds valid data
- res_ready  input  1  consumer takes result when valid&ready
- res_data  output  WIDTH  registered ALU result
- res_id  output  1  requester index that produced res_data
- res_zero  output  1  res_data == 0
- op_count  output  CNT_W  number of accepted operations

Behaviour:
- Reset (async, rst_n low):
  - res_valid=0, res_data=0, res_id=0, res_zero=1, op_count=0.
  - last_grant=1, so requester 0 wins the first contention.
  - req0_ready and req1_ready are 0 while rst_n is low.
- ALU op encoding, applied on the selected operands:
  - 000 AND, 001 OR, 010 ADD (mod 2^WIDTH).
  - 110 SUB (mod 2^WIDTH).
  - 111 unsigned A<B giving 1/0 zero-extended.
  - Any other code gives 0.
- can_accept = !res_valid | res_ready (output register empty, or draining this cycle).
- Grant (combinational):
  - Only req0_valid set: grant 0.
  - Only req1_valid set: grant 1.
  - Both set: grant the index != last_grant.
  - Neither set: no grant.
- reqN_ready = can_accept & grant==N. At most one ready is high in any cycle.
- ready does not depend on the same requester's valid beyond grant selection. The non-granted requester's ready is 0.
- Accept (valid&ready) takes 1 cycle of latency. On the next edge:
  - res_data = ALU(a,b,op) of the granted requester.
  - res_id = N, res_valid=1.
  - res_zero = (result==0).
  - last_grant = N.
  - op_count increments; it wraps to 0 after 2^CNT_W-1.
- Drain without a new accept (res_valid&res_ready, no accept): res_valid goes to 0 next edge.
  - res_data, res_id and res_zero hold their last values.
- Simultaneous drain and accept: res_valid stays 1 and the output register loads the new result. This gives back-to-back throughput.
- Backpressure (res_valid=1, res_ready=0):
  - Both ready outputs are 0.
  - res_data, res_id and res_zero are stable.
  - last_grant is unchanged.
- Requester holds rule: after asserting valid, a requester keeps valid and operands stable until accepted. The block does not latch unaccepted operands.
- last_grant updates only on accept. An idle cycle does not disturb fairness.
- Reset mid-operation: any pending result is discarded immediately and no handshake completes during reset.

Test Plan:
- Single op: req0 valid, A=5, B=3, op=010, res_ready=1 -> req0_ready=1 same cycle; next cycle res_valid=1, res_data=8, res_id=0, op_count=1.
- Op coverage on req1: AND 0xF0F0/0x0FF0=0x00F0; OR=0xFFF0; SUB 3-5=0xFFFFFFFE; SLT 3<5=1; SLT 0xFFFFFFFF<1=0; op=011 -> 0 with res_zero=1.
- Contention: both valid for 4 consecutive cycles, res_ready=1 -> grant order 0,1,0,1; res_id sequence 0,1,0,1; one result per cycle; op_count=4.
- Backpressure: result pending, res_ready=0 for 3 cycles with both requesters valid -> both ready=0, res_data stable; res_ready=1 -> drain and next accept in the same cycle, res_valid stays 1.
- Counter wrap: CNT_W=4, 17 accepted ops -> op_count reads 1.
- Async reset: assert rst_n=0 mid-stream between clock edges -> res_valid=0, op_count=0, readys=0 immediately; after release, first contention grants req0.
